pic_bus_control_sync: RTL
=========================

PIC_BUS_CONTROL_SYNC -- requirements
Module: pic_bus_control_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of data_bus_in and internal_data_bus.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, minimum 2, flop depth of each control-strobe synchroniser.
REQ-003 SHALL have port clk  input  1  single block clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports chip_select_n, read_enable_n, write_enable_n  input  1 each  asynchronous active-low CPU strobes.
REQ-006 SHALL have port address  input  1  A0 register select.
REQ-007 SHALL have port data_bus_in  input  DATA_WIDTH  CPU write data.
REQ-008 SHALL have port internal_data_bus  output  DATA_WIDTH  registered data of the last completed write.
REQ-009 SHALL have ports write_icw1, write_icw2, write_icw3, write_icw4, write_ocw1, write_ocw2, write_ocw3  output  1 each  one-clk command strobes.
REQ-010 SHALL have ports read  output  1, init_done  output  1, single_mode  output  1 (captured ICW1 D1), icw4_needed  output  1 (captured ICW1 D0).

Function
REQ-011 SHALL pass chip_select_n, read_enable_n, write_enable_n each through SYNC_STAGES flops, reset value 1.
REQ-012 SHALL sample data_bus_in and address into holding registers every clk while synced write and chip select are both low.
REQ-013 SHALL detect write completion as a synced write_enable_n 0->1 transition with synced chip_select_n low in the preceding cycle; a write with chip_select_n high at that point is discarded.
REQ-014 SHALL, in the clk after completion, load internal_data_bus from the holding register and assert exactly one strobe for one clk per the decode below.
REQ-015 SHALL implement FSM states UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
REQ-016 SHALL treat A0=0, D4=1 as ICW1 in any state: strobe write_icw1, capture single_mode/icw4_needed, clear init_done, go to WAIT_ICW2.
REQ-017 SHALL, in WAIT_ICW2 on A0=1: strobe write_icw2; next WAIT_ICW3 if single_mode=0, else WAIT_ICW4 if icw4_needed=1, else READY.
REQ-018 SHALL, in WAIT_ICW3 on A0=1: strobe write_icw3; next WAIT_ICW4 if icw4_needed=1, else READY.
REQ-019 SHALL, in WAIT_ICW4 on A0=1: strobe write_icw4; next READY.
REQ-020 SHALL, in READY: A0=1 -> write_ocw1; A0=0,D4=0,D3=0 -> write_ocw2; A0=0,D4=0,D3=1 -> write_ocw3; state unchanged.
REQ-021 SHALL ignore (no strobe, state unchanged) A0=1 writes in UNINIT and A0=0,D4=0 writes in UNINIT/WAIT_ICW2/WAIT_ICW3/WAIT_ICW4.
REQ-022 SHALL drive init_done high exactly while in READY, changing in the same clk as the state.
REQ-023 SHALL drive read registered as synced read low AND synced chip select low AND synced write high; simultaneous read and write gives read=0.
REQ-024 SHALL not generate more than one completion per write pulse, including back-to-back writes separated by one synced high cycle.

Reset
REQ-025 SHALL on reset force state UNINIT, all strobes 0, read 0, init_done 0, single_mode 0, icw4_needed 0, internal_data_bus 0, synchronisers 1, holding registers 0, independent of clk.
REQ-026 SHALL discard any write in progress when reset asserts; a write_enable_n rise after reset release without a preceding synced low produces no strobe.

Configuration
REQ-027 SHALL compile, with PIC_BUS_ERROR_EN defined, an output bus_error (1 bit) set sticky in the clk a write is ignored per REQ-021 and cleared only by reset or by an ICW1.
REQ-028 SHALL, without PIC_BUS_ERROR_EN, omit the bus_error port and its logic entirely; all other behaviour identical.

Structure
REQ-029 SHALL take the FSM state enum and bit-position constants (ICW1_IC4=0, ICW1_SNGL=1, OCW_SEL_D3=3, ICW1_SEL_D4=4) from shared package pic_pkg.
REQ-030 SHALL instantiate sub-module pic_sync_cell (SYNC_STAGES-deep, reset-to-1 synchroniser) once per CPU strobe.

Verification
REQ-031 Bench SHALL cover: reset; write A0=0 0x13, A0=1 0x20, A0=1 0x01 -> strobes icw1, icw2, icw4 in order, no icw3, init_done=1 after icw4.
REQ-032 Bench SHALL cover: ICW1 0x11, ICW2 0x08, ICW3 0x04, ICW4 0x01 -> icw1..icw4 each one clk, internal_data_bus matches each value, READY reached.
REQ-033 Bench SHALL cover: in READY, A0=1 0xFE, A0=0 0x20, A0=0 0x0B -> write_ocw1, write_ocw2, write_ocw3 respectively, init_done stays 1.
REQ-034 Bench SHALL cover: in UNINIT, A0=1 0x55 -> no strobe, state UNINIT; with PIC_BUS_ERROR_EN bus_error=1 until next ICW1 0x13.
REQ-035 Bench SHALL cover: chip_select_n raised before write_enable_n rises -> no strobe; read_enable_n and write_enable_n low together -> read=0.
REQ-036 Bench SHALL cover: reset asserted mid-WAIT_ICW3 -> immediate UNINIT, init_done=0, internal_data_bus=0, no strobe on the following write_enable_n rise.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and bit positions for the PIC CPU bus controller.
package pic_pkg;

    typedef enum logic [2:0] {
        UNINIT,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    typedef struct packed {
        logic ocw3;
        logic ocw2;
        logic ocw1;
        logic icw4;
        logic icw3;
        logic icw2;
        logic icw1;
    } strobe_t;

    localparam int ICW1_IC4    = 0;
    localparam int ICW1_SNGL   = 1;
    localparam int OCW_SEL_D3  = 3;
    localparam int ICW1_SEL_D4 = 4;

endpackage

// File: rtl/pic_sync_cell.sv
// Multi-flop synchroniser for one asynchronous active-low strobe.
module pic_sync_cell #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    // Resets to the inactive (high) level so no false edge appears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sr <= '1;
        else       sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/pic_bus_control_sync.sv
// PIC CPU bus controller: strobe sync, write decode, ICW/OCW sequencing.
// Define PIC_BUS_ERROR_EN to add the sticky bus_error output.
module pic_bus_control_sync
    import pic_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chip_select_n,
    input  logic                  read_enable_n,
    input  logic                  write_enable_n,
    input  logic                  address,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    output logic [DATA_WIDTH-1:0] internal_data_bus,
    output logic                  write_icw1,
    output logic                  write_icw2,
    output logic                  write_icw3,
    output logic                  write_icw4,
    output logic                  write_ocw1,
    output logic                  write_ocw2,
    output logic                  write_ocw3,
    output logic                  read,
    output logic                  init_done,
    output logic                  single_mode,
    output logic                  icw4_needed
`ifdef PIC_BUS_ERROR_EN
    ,
    output logic                  bus_error
`endif
);

    logic cs_s, rd_s, wr_s;
    logic cs_q, wr_q;
    logic done;
    logic hold_addr;
    logic [DATA_WIDTH-1:0] hold_data;
    state_t  state, state_nx;
    strobe_t strb, strb_nx;
    logic ignored;
    logic cap_icw1;

    pic_sync_cell #(.STAGES(SYNC_STAGES)) u_cs (
        .clk(clk), .reset(reset), .d(chip_select_n), .q(cs_s)
    );
    pic_sync_cell #(.STAGES(SYNC_STAGES)) u_rd (
        .clk(clk), .reset(reset), .d(read_enable_n), .q(rd_s)
    );
    pic_sync_cell #(.STAGES(SYNC_STAGES)) u_wr (
        .clk(clk), .reset(reset), .d(write_enable_n), .q(wr_s)
    );

    // Completion: synced write rises, chip select was low the cycle before.
    assign done = wr_s & ~wr_q & ~cs_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q      <= 1'b1;
            wr_q      <= 1'b1;
            hold_addr <= 1'b0;
            hold_data <= '0;
            read      <= 1'b0;
        end else begin
            cs_q <= cs_s;
            wr_q <= wr_s;
            if (!wr_s && !cs_s) begin
                hold_addr <= address;
                hold_data <= data_bus_in;
            end
            read <= ~rd_s & ~cs_s & wr_s;
        end
    end

    always_comb begin
        state_nx = state;
        strb_nx  = '0;
        ignored  = 1'b0;
        cap_icw1 = 1'b0;
        if (done) begin
            if (!hold_addr && hold_data[ICW1_SEL_D4]) begin
                strb_nx.icw1 = 1'b1;
                cap_icw1     = 1'b1;
                state_nx     = WAIT_ICW2;
            end else begin
                unique case (state)
                    UNINIT: ignored = 1'b1;
                    WAIT_ICW2: begin
                        if (hold_addr) begin
                            strb_nx.icw2 = 1'b1;
                            if (!single_mode)    state_nx = WAIT_ICW3;
                            else if (icw4_needed) state_nx = WAIT_ICW4;
                            else                  state_nx = READY;
                        end else begin
                            ignored = 1'b1;
                        end
                    end
                    WAIT_ICW3: begin
                        if (hold_addr) begin
                            strb_nx.icw3 = 1'b1;
                            state_nx = icw4_needed ? WAIT_ICW4 : READY;
                        end else begin
                            ignored = 1'b1;
                        end
                    end
                    WAIT_ICW4: begin
                        if (hold_addr) begin
                            strb_nx.icw4 = 1'b1;
                            state_nx     = READY;
                        end else begin
                            ignored = 1'b1;
                        end
                    end
                    READY: begin
                        if (hold_addr)                    strb_nx.ocw1 = 1'b1;
                        else if (hold_data[OCW_SEL_D3])   strb_nx.ocw3 = 1'b1;
                        else                              strb_nx.ocw2 = 1'b1;
                    end
                    default: state_nx = UNINIT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= UNINIT;
            strb              <= '0;
            internal_data_bus <= '0;
            single_mode       <= 1'b0;
            icw4_needed       <= 1'b0;
        end else begin
            state <= state_nx;
            strb  <= strb_nx;
            if (done) internal_data_bus <= hold_data;
            if (cap_icw1) begin
                single_mode <= hold_data[ICW1_SNGL];
                icw4_needed <= hold_data[ICW1_IC4];
            end
        end
    end

    assign write_icw1 = strb.icw1;
    assign write_icw2 = strb.icw2;
    assign write_icw3 = strb.icw3;
    assign write_icw4 = strb.icw4;
    assign write_ocw1 = strb.ocw1;
    assign write_ocw2 = strb.ocw2;
    assign write_ocw3 = strb.ocw3;
    assign init_done  = (state == READY);

`ifdef PIC_BUS_ERROR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         bus_error <= 1'b0;
        else if (cap_icw1) bus_error <= 1'b0;
        else if (ignored)  bus_error <= 1'b1;
    end
`else
    logic unused_ignored;
    assign unused_ignored = ignored;
`endif

endmodule
